// File: rtl/stack8_ctrl_if.sv
// Bus bundle for stack8_ctrl: the user push/pop port plus the RAM8 side.
// The slave modport is the controller's view.
interface stack8_ctrl_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
);
    logic                 push;
    logic                 pop;
    logic [WIDTH-1:0]     data_in;
    logic [WIDTH-1:0]     data_out;
    logic                 valid_out;
    logic                 err;
    logic                 full;
    logic                 empty;
    logic [ADDR_BITS:0]   count;
    logic [WIDTH-1:0]     ram_in;
    logic                 ram_load;
    logic [ADDR_BITS-1:0] ram_address;
    logic [WIDTH-1:0]     ram_out;

    modport slave (
        input  push, pop, data_in, ram_out,
        output data_out, valid_out, err, full, empty, count,
               ram_in, ram_load, ram_address
    );

    modport master (
        output push, pop, data_in, ram_out,
        input  data_out, valid_out, err, full, empty, count,
               ram_in, ram_load, ram_address
    );
endinterface

// File: rtl/stack8_ctrl.sv
// LIFO controller over an external RAM8 (combinational read, synchronous write).
// The stack pointer is the only real state; flags and RAM controls derive from it.
module stack8_ctrl #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    stack8_ctrl_if.slave bus
);
    localparam logic [ADDR_BITS:0] SP_MAX = (ADDR_BITS+1)'(1 << ADDR_BITS);
    localparam logic [ADDR_BITS:0] SP_ONE = (ADDR_BITS+1)'(1);

    logic [ADDR_BITS:0]   r_sp;
    logic [WIDTH-1:0]     r_data_out;
    logic                 r_valid;
    logic                 r_err;

    logic                 w_empty;
    logic                 w_full;
    logic [ADDR_BITS:0]   w_sp_dec;
    logic [ADDR_BITS:0]   w_sp_inc;
    logic [ADDR_BITS-1:0] w_addr;
    logic                 w_load;

    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == SP_MAX);
    assign w_sp_dec = r_sp - SP_ONE;
    assign w_sp_inc = r_sp + SP_ONE;

    // Push into a fresh slot addresses sp; everything else (pop, replace,
    // idle peek, rejected push) addresses the current top at sp-1.
    always_comb begin
        w_addr = w_sp_dec[ADDR_BITS-1:0];
        if (bus.push && (w_empty || (!bus.pop && !w_full)))
            w_addr = r_sp[ADDR_BITS-1:0];
    end

    // Reset gates the write enable combinationally so a push in flight never lands.
    assign w_load = !reset && bus.push && (bus.pop || !w_full);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp       <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (bus.push && bus.pop) begin
                if (w_empty) begin
                    r_sp  <= w_sp_inc;
                    r_err <= 1'b1;
                end else begin
                    r_data_out <= bus.ram_out;
                    r_valid    <= 1'b1;
                end
            end else if (bus.push) begin
                if (w_full) r_err <= 1'b1;
                else        r_sp  <= w_sp_inc;
            end else if (bus.pop) begin
                if (w_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_data_out <= bus.ram_out;
                    r_valid    <= 1'b1;
                    r_sp       <= w_sp_dec;
                end
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.valid_out   = r_valid;
    assign bus.err         = r_err;
    assign bus.count       = r_sp;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.ram_in      = bus.data_in;
    assign bus.ram_load    = w_load;
    assign bus.ram_address = w_addr;
endmodule

// File: tb/tb_stack8_ctrl.sv
// Directed bench for stack8_ctrl: queue-based stack model checked every cycle,
// plus literal checkpoints on the key scenarios.
module tb_stack8_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    stack8_ctrl_if #(.WIDTH(16), .ADDR_BITS(3)) bus ();

    stack8_ctrl #(.WIDTH(16), .ADDR_BITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM8: synchronous write, combinational read, never cleared.
    logic [15:0] mem [8];
    always @(posedge clk) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    assign bus.ram_out = mem[bus.ram_address];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference stack: a queue of words, top at the back.
    int unsigned q[$];
    int unsigned m_dout  = 0;
    bit          m_valid = 0;
    bit          m_err   = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_dout = 0; m_valid = 0; m_err = 0;
        end else begin
            m_valid = 0; m_err = 0;
            if (bus.push && bus.pop) begin
                if (q.size() == 0) begin
                    q.push_back(bus.data_in);
                    m_err = 1;
                end else begin
                    m_dout = q[q.size()-1];
                    m_valid = 1;
                    q[q.size()-1] = bus.data_in;
                end
            end else if (bus.push) begin
                if (q.size() == 8) m_err = 1;
                else q.push_back(bus.data_in);
            end else if (bus.pop) begin
                if (q.size() == 0) m_err = 1;
                else begin
                    m_dout = q.pop_back();
                    m_valid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        int exp_addr;
        bit exp_load;
        sz = q.size();
        exp_load = !reset && bus.push && (bus.pop || sz < 8);
        if (bus.push && (sz == 0 || (!bus.pop && sz < 8))) exp_addr = sz;
        else exp_addr = (sz - 1) & 7;
        chk("m_count",    32'(bus.count),       32'(sz));
        chk("m_empty",    32'(bus.empty),       32'(sz == 0));
        chk("m_full",     32'(bus.full),        32'(sz == 8));
        chk("m_data_out", 32'(bus.data_out),    m_dout);
        chk("m_valid",    32'(bus.valid_out),   32'(m_valid));
        chk("m_err",      32'(bus.err),         32'(m_err));
        chk("m_ram_load", 32'(bus.ram_load),    32'(exp_load));
        chk("m_ram_addr", 32'(bus.ram_address), 32'(exp_addr));
        chk("m_ram_in",   32'(bus.ram_in),      32'(bus.data_in));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input bit p, input bit o, input logic [15:0] d);
        bus.push = p;
        bus.pop = o;
        bus.data_in = d;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 16'h0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full), 0);
        chk("rst_dout",  32'(bus.data_out), 0);
        chk("rst_valid", 32'(bus.valid_out), 0);
        chk("rst_err",   32'(bus.err), 0);
        reset = 1'b0;
        tick();

        // First push after reset lands at address 0.
        drv(1, 0, 16'h1234);
        #1;
        chk("p1234_load", 32'(bus.ram_load), 1);
        chk("p1234_addr", 32'(bus.ram_address), 0);
        chk("p1234_in",   32'(bus.ram_in), 32'h1234);
        tick();
        chk("p1234_count", 32'(bus.count), 1);
        chk("p1234_empty", 32'(bus.empty), 0);
        drv(0, 0, 16'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Fill to 8, then overflow.
        for (int i = 1; i <= 8; i++) begin
            drv(1, 0, 16'(i));
            tick();
        end
        chk("fill_full", 32'(bus.full), 1);
        drv(1, 0, 16'h0009);
        #1;
        chk("ovf_load", 32'(bus.ram_load), 0);
        tick();
        chk("ovf_err",   32'(bus.err), 1);
        chk("ovf_count", 32'(bus.count), 8);
        drv(0, 0, 16'h0);
        tick();
        chk("ovf_err_pulse", 32'(bus.err), 0);

        // Drain, then underflow.
        for (int i = 0; i < 8; i++) begin
            drv(0, 1, 16'h0);
            tick();
            chk("drain_dout",  32'(bus.data_out), 32'(8 - i));
            chk("drain_valid", 32'(bus.valid_out), 1);
        end
        chk("drain_empty", 32'(bus.empty), 1);
        tick();
        chk("unf_err", 32'(bus.err), 1);
        chk("unf_valid", 32'(bus.valid_out), 0);
        chk("unf_dout", 32'(bus.data_out), 1);
        drv(0, 0, 16'h0);
        tick();

        // Replace top with simultaneous push+pop.
        drv(1, 0, 16'hAAAA); tick();
        drv(1, 0, 16'hBBBB); tick();
        drv(1, 1, 16'hCCCC); tick();
        chk("rep_dout",  32'(bus.data_out), 32'hBBBB);
        chk("rep_valid", 32'(bus.valid_out), 1);
        chk("rep_count", 32'(bus.count), 2);
        drv(0, 1, 16'h0); tick();
        chk("rep_pop1", 32'(bus.data_out), 32'hCCCC);
        tick();
        chk("rep_pop2", 32'(bus.data_out), 32'hAAAA);
        drv(0, 0, 16'h0); tick();

        // Push+pop on empty: push wins, pop flagged.
        drv(1, 1, 16'h5555); tick();
        chk("pe_count", 32'(bus.count), 1);
        chk("pe_err",   32'(bus.err), 1);
        chk("pe_valid", 32'(bus.valid_out), 0);
        drv(0, 1, 16'h0); tick();
        chk("pe_pop", 32'(bus.data_out), 32'h5555);
        drv(0, 0, 16'h0); tick();

        // Reset asserted mid-push at count 3, checked before any clock edge.
        drv(1, 0, 16'h0011); tick();
        drv(1, 0, 16'h0022); tick();
        drv(1, 0, 16'h0033); tick();
        drv(1, 0, 16'h0044);
        #1;
        chk("mid_load_pre", 32'(bus.ram_load), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_load",  32'(bus.ram_load), 0);
        chk("mid_count", 32'(bus.count), 0);
        chk("mid_empty", 32'(bus.empty), 1);
        chk("mid_dout",  32'(bus.data_out), 0);
        drv(0, 0, 16'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
